// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and defaults for the UART TX arbiter.
// Optional feature macro: ARB_TIMEOUT_EN (grant timeout in S_GRANT).
package uart_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_LOAD,
    S_WAIT
  } arb_state_t;

  localparam int SRC_WATCH   = 0;
  localparam int SRC_SR04    = 1;
  localparam int SRC_DHT     = 2;

  localparam int NREQ_DEF    = 3;
  localparam int TIMEOUT_DEF = 100_000;

endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: combinational round-robin search.
// First requester after rr_ptr (mod NREQ) wins, one-hot.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int PW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic            any,
  output logic [NREQ-1:0] win
);

  logic [PW:0] idx;
  logic        found;

  // Scan NREQ slots starting after rr_ptr, wrapping explicitly
  always_comb begin
    any   = |req;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(i + 1);
      if (idx >= (PW+1)'(NREQ))
        idx = idx - (PW+1)'(NREQ);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked share of one uart_tx.
// Optional macro ARB_TIMEOUT_EN revokes a grant stalled TIMEOUT_CYC cycles.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ        = NREQ_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] req_last,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0] req_ready,
  output logic [NREQ-1:0] grant,
  output logic            tx_start,
  output logic [7:0]      tx_data,
  input  logic            tx_done
);

  localparam int PW = $clog2(NREQ);

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            last_q, last_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic            tx_start_q, tx_start_d;

  logic            any;
  logic [NREQ-1:0] win;
  logic [PW-1:0]   win_idx;
  logic [7:0]      sel_data;
  logic            sel_valid;
  logic            sel_last;
  logic            sel_req;
  logic            tmo_hit;

  uart_rr_picker #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .any    (any),
    .win    (win)
  );

  // Route the granted source's lane and encode the picker winner
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_req   = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        sel_data  = req_data[8*i +: 8];
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_req   = req[i];
      end
      if (win[i])
        win_idx = PW'(i);
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

  logic [TW-1:0] tmo_q, tmo_d;
  logic [TW-1:0] tmo_inc;
  logic          stall;

  // Count stalled S_GRANT cycles; clear on a byte or leaving S_GRANT
  always_comb begin
    stall   = (state_q == S_GRANT) && !sel_valid && sel_req;
    tmo_inc = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
    tmo_hit = stall && (tmo_inc == TMO_MAX);
    tmo_d   = '0;
    if (stall && !tmo_hit)
      tmo_d = tmo_inc;
  end

  // Timeout counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = (TIMEOUT_CYC == 0);
`endif

  // Next-state and output logic of the arbitration FSM
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    tx_data_d   = tx_data_q;
    last_d      = last_q;
    req_ready_d = '0;
    tx_start_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any) begin
          grant_d  = win;
          rr_ptr_d = win_idx;
          state_d  = S_GRANT;
        end
      end
      S_GRANT: begin
        if (sel_valid) begin
          tx_data_d   = sel_data;
          last_d      = sel_last;
          req_ready_d = grant_q;
          state_d     = S_LOAD;
        end else if (!sel_req || tmo_hit) begin
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        tx_start_d = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          if (last_q) begin
            grant_d = '0;
            state_d = S_IDLE;
          end else begin
            state_d = S_GRANT;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= PW'(NREQ - 1);
      tx_data_q   <= 8'h00;
      last_q      <= 1'b0;
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      tx_data_q   <= tx_data_d;
      last_q      <= last_d;
      req_ready_q <= req_ready_d;
      tx_start_q  <= tx_start_d;
    end
  end

  assign grant     = grant_q;
  assign req_ready = req_ready_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;

endmodule
